// File: rtl/fir_pkg.sv
// fir_pkg: shared pacer FSM state enum and default sample width / rate divider.
package fir_pkg;
    typedef enum logic {ST_WAIT = 1'b0, ST_PRESENT = 1'b1} state_t;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_RATE_DIV = 1134;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-two sample FIFO; a pop frees a slot for a same-cycle push when full.
module sample_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       count_q, count_d;
    logic              do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d    = do_push ? wr_q + PTR_ONE : wr_q;
        rd_d    = do_pop ? rd_q + PTR_ONE : rd_q;
        count_d = (do_push == do_pop) ? count_q : do_push ? count_q + CNT_ONE : count_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end

    always_ff @(posedge clk)
        if (do_push) mem_q[wr_q] <= din;

    assign dout  = mem_q[rd_q];
    assign full  = count_q == CNT_FULL;
    assign empty = count_q == '0;
    assign count = count_q;
endmodule

// File: rtl/axis_sample_pacer.sv
// axis_sample_pacer: releases one queued sample per RATE_DIV cycles; AXIS_SAMPLE_PACER_UNDERRUN_CNT_EN adds underrun_cnt.
module axis_sample_pacer
    import fir_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 8,
    parameter int RATE_DIV = DEF_RATE_DIV
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              m_axis_data_tvalid,
    output logic [DATA_W-1:0] m_axis_data_tdata,
    input  logic              m_axis_data_tready,
    output logic              underrun,
    output logic              late
`ifdef AXIS_SAMPLE_PACER_UNDERRUN_CNT_EN
    ,output logic [15:0]      underrun_cnt
`endif
);
    localparam int CW = RATE_DIV > 1 ? $clog2(RATE_DIV) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(RATE_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] tdata_q, tdata_d, fifo_dout;
    logic              underrun_q, underrun_d, late_q, late_d;
    logic              tick, pop, hs, fifo_full, fifo_empty;
    logic [AW:0]       fifo_count;

    sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (aclk),
        .rst_n (aresetn),
        .push  (in_valid && in_ready),
        .pop   (pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tick     = cnt_q == CNT_LAST;
    assign cnt_d    = tick ? '0 : cnt_q + CNT_ONE;
    assign hs       = state_q == ST_PRESENT && m_axis_data_tready;
    // A pop on the same cycle frees the slot a full FIFO would otherwise refuse.
    assign in_ready = !fifo_full || pop;

    always_comb begin
        state_d    = state_q;
        tdata_d    = tdata_q;
        underrun_d = underrun_q;
        late_d     = late_q;
        pop        = 1'b0;
        if (state_q == ST_WAIT) begin
            if (tick && fifo_empty) underrun_d = 1'b1;
            if (tick && !fifo_empty) begin
                pop     = 1'b1;
                tdata_d = fifo_dout;
                state_d = ST_PRESENT;
            end
        end else begin
            state_d = hs ? ST_WAIT : ST_PRESENT;
            late_d  = late_q || (tick && !hs);
        end
    end

    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            state_q    <= ST_WAIT;
            cnt_q      <= '0;
            tdata_q    <= '0;
            underrun_q <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tdata_q    <= tdata_d;
            underrun_q <= underrun_d;
            late_q     <= late_d;
        end

    always_ff @(posedge aclk)
        if (aresetn) assert (fifo_empty == (fifo_count == '0));

    assign m_axis_data_tvalid = state_q == ST_PRESENT;
    assign m_axis_data_tdata  = tdata_q;
    assign underrun           = underrun_q;
    assign late               = late_q;

`ifdef AXIS_SAMPLE_PACER_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;
    assign ucnt_d = (tick && state_q == ST_WAIT && fifo_empty && ucnt_q != 16'hFFFF) ? ucnt_q + 16'd1 : ucnt_q;
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) ucnt_q <= '0;
        else ucnt_q <= ucnt_d;
    assign underrun_cnt = ucnt_q;
`endif
endmodule
